// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: column drive, row debounce, ghost rejection, nibble entry register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_matrix_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_DIV        = 16,
    parameter int DIGITS          = 4,
    parameter int HEX_MAP         = 1,
`ifdef KEYPAD_REPEAT_EN
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
`endif
    localparam int KW             = $clog2(ROWS*COLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ROWS-1:0]       row_in,
    input  logic                  clr,
    output logic [COLS-1:0]       col_out,
    output logic                  key_valid,
    output logic [KW-1:0]         key_code,
    output logic                  key_held,
    output logic [4*DIGITS-1:0]   val
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int NW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] S_SCAN  = 2'd0;
    localparam logic [1:0] S_DEB   = 2'd1;
    localparam logic [1:0] S_PRESS = 2'd2;
    localparam logic [1:0] S_REL   = 2'd3;

    // nibble for key code k lives at bits [4k+3:4k]
    localparam logic [63:0] HEX_LUT = 64'h123A_456B_789C_E0FD;

    logic [ROWS-1:0] row_s1, row_s2, pat, low;
    logic [CW-1:0]   col, col_p1, col_p2, col_next;
    logic [DW-1:0]   div;
    logic [NW-1:0]   cnt;
    logic [1:0]      state;
    logic [RW-1:0]   row_r, row_idx;
    logic [KW-1:0]   code_w;
    logic [3:0]      code_lo, nib;
    logic            ones, one_low, tag_ok, deb_done, accept, rep_fire, evt;

    always_comb begin
        col_out = '1;
        col_out[col] = 1'b0;
    end

    assign low      = ~row_s2;
    assign ones     = &row_s2;
    assign one_low  = (low != '0) && ((low & (low - 1'b1)) == '0);
    // col_p2 is the column that was driven when the row_s2 sample was taken
    assign tag_ok   = (col_p2 == col);
    assign col_next = (col == CW'(COLS-1)) ? '0 : col + 1'b1;
    assign deb_done = (cnt == NW'(DEBOUNCE_CYCLES-1));
    assign accept   = (state == S_DEB) && tag_ok && (row_s2 == pat) && deb_done;

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < ROWS; i++)
            if (low[i]) row_idx = RW'(i);
    end

    assign code_w  = KW'(row_r) * KW'(COLS) + KW'(col);
    assign code_lo = 4'(code_w);
    assign nib     = (HEX_MAP != 0) ? HEX_LUT[{code_lo, 2'b00} +: 4] : code_lo;

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW  = $clog2(RMAX + 1);

    logic [RPW-1:0] rep_cnt, rep_lim;
    logic           rep_first;

    assign rep_lim  = rep_first ? RPW'(REPEAT_DELAY-1) : RPW'(REPEAT_RATE-1);
    assign rep_fire = (state == S_PRESS) && (rep_cnt == rep_lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (state == S_PRESS) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt   <= rep_cnt + 1'b1;
            end
        end else begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign evt = accept | rep_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1    <= '1;
            row_s2    <= '1;
            col       <= '0;
            col_p1    <= '0;
            col_p2    <= '0;
            div       <= '0;
            cnt       <= '0;
            state     <= S_SCAN;
            pat       <= '1;
            row_r     <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
            val       <= '0;
        end else begin
            row_s1    <= row_in;
            row_s2    <= row_s1;
            col_p1    <= col;
            col_p2    <= col_p1;
            key_valid <= evt;

            if (accept) begin
                key_code <= code_w;
                key_held <= 1'b1;
            end

            if (evt)
                val <= {(clr ? '0 : val[4*DIGITS-5:0]), nib};
            else if (clr)
                val <= '0;

            case (state)
                S_SCAN: begin
                    if (div == DW'(SCAN_DIV-1)) begin
                        div <= '0;
                        if (one_low) begin
                            // return to the column the sample belongs to
                            state <= S_DEB;
                            cnt   <= '0;
                            pat   <= row_s2;
                            row_r <= row_idx;
                            col   <= col_p2;
                        end else begin
                            col <= col_next;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                S_DEB: begin
                    if (tag_ok) begin
                        if (row_s2 == pat) begin
                            if (deb_done) state <= S_PRESS;
                            else          cnt   <= cnt + 1'b1;
                        end else begin
                            state <= S_SCAN;
                            col   <= col_next;
                            div   <= '0;
                        end
                    end
                end
                S_PRESS: begin
                    if (tag_ok && ones) begin
                        state <= S_REL;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (tag_ok) begin
                        if (ones) begin
                            if (deb_done) begin
                                key_held <= 1'b0;
                                state    <= S_SCAN;
                                col      <= col_next;
                                div      <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else if (row_s2 == pat) begin
                            state <= S_PRESS;
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner with a combinational 4x4 keypad model.
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [3:0]  row_in, col_out;
    logic        key_valid, key_held;
    logic [3:0]  key_code;
    logic [15:0] val;
    logic        pressed [4][4];

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] val;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    exp_t ne;
    int   n_cmp = 0;
    int   n_err = 0;

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(4), .DEBOUNCE_CYCLES(4),
        .SCAN_DIV(2), .DIGITS(4), .HEX_MAP(1)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .clr(clr),
        .col_out(col_out), .key_valid(key_valid), .key_code(key_code),
        .key_held(key_held), .val(val)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got code %0h val %0h expected no event", key_code, val);
            end else begin
                mon_e = sbq.pop_front();
                check("key_code", 32'(key_code), 32'(mon_e.code));
                check("val", 32'(val), 32'(mon_e.val));
                check("key_held", 32'(key_held), 32'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    task automatic wait_pulse(input string name);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (key_valid) got = 1;
        end
        if (!got) fail_now(name);
    endtask

    task automatic wait_unheld(input string name);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (!key_held) got = 1;
        end
        if (!got) fail_now(name);
    endtask

    task automatic hit(input int r, input int c, input logic [3:0] code, input logic [15:0] v);
        ne.code = code;
        ne.val  = v;
        sbq.push_back(ne);
        pressed[r][c] = 1'b1;
        wait_pulse("press_timeout");
        release_all();
        wait_unheld("release_timeout");
        tick(6);
    endtask

    task automatic check_reset_outputs();
        check("rst_col_out", 32'(col_out), 32'h0000_000E);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_held", 32'(key_held), 32'd0);
        check("rst_val", 32'(val), 32'd0);
    endtask

    int          kr [5]   = '{3, 3, 3, 2, 2};
    int          kc [5]   = '{3, 2, 1, 3, 2};
    logic [3:0]  kk [5]   = '{4'd15, 4'd14, 4'd13, 4'd11, 4'd10};
    logic [15:0] kv [5]   = '{16'hD1C1, 16'h1C12, 16'hC123, 16'h1234, 16'h2345};

    initial begin
        logic [3:0] exp_col;
        logic [3:0] seen;
        bit         got;

        rst = 1'b1;
        clr = 1'b0;
        release_all();
        tick(3);
        check_reset_outputs();
        rst = 1'b0;

        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_col = 4'b1111;
            exp_col[(k/2)%4] = 1'b0;
            check("scan_col_out", 32'(col_out), 32'(exp_col));
        end

        hit(0, 0, 4'd0, 16'h000D);
        hit(3, 3, 4'd15, 16'h00D1);

        for (int i = 0; i < 15; i++) begin
            pressed[1][0] = 1'b1;
            tick(2);
            pressed[1][0] = 1'b0;
            tick(2);
        end
        tick(10);
        hit(1, 0, 4'd4, 16'h0D1C);

        pressed[0][1] = 1'b1;
        pressed[2][1] = 1'b1;
        seen = '0;
        repeat (64) begin
            @(negedge clk);
            seen = seen | ~col_out;
        end
        check("ghost_scan", 32'(seen), 32'h0000_000F);
        release_all();
        tick(10);

        for (int i = 0; i < 5; i++)
            hit(kr[i], kc[i], kk[i], kv[i]);
        check("val_five_keys", 32'(val), 32'h0000_2345);

        ne.code = 4'd9;
        ne.val  = 16'h0006;
        sbq.push_back(ne);
        clr = 1'b1;
        pressed[2][1] = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (key_valid) begin
                got = 1;
                clr = 1'b0;
            end
        end
        clr = 1'b0;
        if (!got) fail_now("clr_press_timeout");
        release_all();
        wait_unheld("clr_release_timeout");
        tick(4);
        check("val_after_clr_accept", 32'(val), 32'h0000_0006);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("val_clr_alone", 32'(val), 32'd0);
        tick(4);

        ne.code = 4'd0;
        ne.val  = 16'h000D;
        sbq.push_back(ne);
        pressed[0][0] = 1'b1;
        wait_pulse("pre_reset_timeout");
        tick(3);
        check("held_before_reset", 32'(key_held), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        tick(2);
        ne.code = 4'd0;
        ne.val  = 16'h000D;
        sbq.push_back(ne);
        rst = 1'b0;
        wait_pulse("re_report_timeout");
        tick(20);
        release_all();
        wait_unheld("final_release_timeout");
        tick(40);
        check("queue_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
